// File: rtl/mips_boot_mem.sv
// Program/data RAM for the 8-bit multicycle MIPS core with a pin-driven boot loader.
// LOAD mode holds the core in reset while strobed bytes fill the RAM; RUN mode serves the core.
module mips_boot_mem #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned ADRBITS     = 6,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               run,
   input  logic               load_strobe,
   input  logic [WIDTH-1:0]   load_data,
   input  logic [ADRBITS-1:0] core_adr,
   input  logic               core_memread,
   input  logic               core_memwrite,
   input  logic [WIDTH-1:0]   core_writedata,
   output logic [WIDTH-1:0]   core_memdata,
   output logic               core_reset,
   output logic [ADRBITS-1:0] load_ptr,
   output logic [ADRBITS:0]   load_count,
   output logic               overflow
);

   localparam int unsigned DEPTH = 2 ** ADRBITS;
   localparam logic [ADRBITS:0] FULL_COUNT = {1'b1, {ADRBITS{1'b0}}};

   typedef enum logic {LOAD, RUN} state_t;

   state_t                 state, next_state;
   logic [SYNC_STAGES-1:0] run_sync, strobe_sync;
   logic                   strobe_prev;
   logic                   run_s, strobe_s, strobe_edge;
   logic [ADRBITS-1:0]     ptr_next;
   logic [ADRBITS:0]       count_next;
   logic                   overflow_next;
   logic                   load_we, core_we;
   logic [WIDTH-1:0]       mem [DEPTH];

   // Reads are always combinational, so the request strobe carries no information here.
   logic unused_memread;
   assign unused_memread = core_memread;

   assign run_s       = run_sync[SYNC_STAGES-1];
   assign strobe_s    = strobe_sync[SYNC_STAGES-1];
   assign strobe_edge = strobe_s & ~strobe_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_sync    <= '0;
         strobe_sync <= '0;
         strobe_prev <= 1'b0;
         state       <= LOAD;
         load_ptr    <= '0;
         load_count  <= '0;
         overflow    <= 1'b0;
      end else begin
         run_sync    <= {run_sync[SYNC_STAGES-2:0], run};
         strobe_sync <= {strobe_sync[SYNC_STAGES-2:0], load_strobe};
         strobe_prev <= strobe_s;
         state       <= next_state;
         load_ptr    <= ptr_next;
         load_count  <= count_next;
         overflow    <= overflow_next;
      end
   end

   always_comb begin
      next_state    = state;
      ptr_next      = load_ptr;
      count_next    = load_count;
      overflow_next = overflow;
      load_we       = 1'b0;
      core_we       = 1'b0;
      core_reset    = 1'b1;
      core_memdata  = '0;
      unique case (state)
         LOAD: begin
            // A byte arriving together with run_s is still written before leaving LOAD.
            if (strobe_edge) begin
               load_we  = 1'b1;
               ptr_next = load_ptr + 1'b1;
               if (load_count != FULL_COUNT)
                  count_next = load_count + 1'b1;
               if (&load_ptr)
                  overflow_next = 1'b1;
            end
            if (run_s)
               next_state = RUN;
         end
         RUN: begin
            core_reset   = 1'b0;
            core_memdata = mem[core_adr];
            core_we      = core_memwrite;
            if (!run_s) begin
               next_state    = LOAD;
               ptr_next      = '0;
               count_next    = '0;
               overflow_next = 1'b0;
            end
         end
         default: next_state = LOAD;
      endcase
   end

   // RAM contents deliberately survive rst_n.
   always_ff @(posedge clk) begin
      if (load_we)
         mem[load_ptr] <= load_data;
      else if (core_we)
         mem[core_adr] <= core_writedata;
   end

endmodule
